dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: target side of the CPU MEM-stage load/store port.
//  Accepts one request per valid/ready handshake, models WAIT_CYCLES of access latency,
//  returns one response per request via valid/ready. Replaces the zero-wait dram for latency testing.
// PARAMETERS
//  ADDR_W       14  word-address bits; depth = 2**ADDR_W words (64KB at default)
//  DATA_W       32  data width; byte lanes = DATA_W/8
//  WAIT_CYCLES  2   extra cycles between acceptance and response (0 allowed)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       responder can accept
//  req_we     in   1       1=store, 0=load
//  req_addr   in   32      byte address; word index = req_addr[ADDR_W+1:2], [1:0] ignored
//  req_wdata  in   DATA_W  store data
//  req_be     in   DATA_W/8 byte enables (stores only)
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       requester takes response
//  rsp_rdata  out  DATA_W  load data / post-store word
//  busy       out  1       transaction in flight (state != IDLE)
//  rsp_err    out  1       only when DMEM_RANGE_CHECK_EN defined
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0,
//   busy=0, wait counter=0, rsp_err=0. Array contents NOT reset (X until written).
//  FSM states IDLE, WAIT, RESP:
//   IDLE: req_ready=1. On req_valid: latch we/addr/wdata/be; -> WAIT (cnt=WAIT_CYCLES-1),
//         or directly -> RESP if WAIT_CYCLES==0.
//   WAIT: req_ready=0; cnt decrements each cycle; at cnt==0 -> RESP.
//   RESP: rsp_valid=1, rsp_rdata stable; on rsp_ready -> IDLE.
//  Latency: acceptance edge to rsp_valid high = WAIT_CYCLES+1 cycles.
//  Access commit: on the edge entering RESP. Load: rsp_rdata=mem[idx].
//   Store: mem[idx] byte-lane merge under req_be; rsp_rdata=merged word. be=0 -> no change, still responds.
//  req_ready=0 in WAIT and RESP: no overlap; peak throughput 1 txn per WAIT_CYCLES+2 cycles.
//  Inputs are sampled only at acceptance; changes during WAIT/RESP are ignored.
//  rsp_ready high outside RESP: ignored. rsp_valid held indefinitely until rsp_ready.
//  Reset mid-operation: in-flight txn dropped; a store not yet committed is never written.
//  Address bits above ADDR_W+1: see CONFIGURATION.
// CONFIGURATION
//  DMEM_RANGE_CHECK_EN defined: req_addr[31:ADDR_W+2]!=0 -> no array access,
//   rsp_rdata=0, rsp_err=1 with that response (same latency); rsp_err=0 otherwise.
//  Undefined: upper bits ignored, address wraps modulo depth; rsp_err port absent.
// STRUCTURE
//  Package dmem_pkg: state enum typedef (IDLE/WAIT/RESP), BYTE_LANES = DATA_W/8 constant,
//   byte-merge function merge_be(old, new, be).
//  Sub-module dmem_array: storage; async read, sync write with per-byte enables.
//  dmem_responder holds FSM, wait counter, request latches, response register.
// TESTING
//  1 Reset: rst_n=0 mid-WAIT -> rsp_valid=0, busy=0, req_ready=1 after release; pending store absent on readback.
//  2 Store 0xDEADBEEF @0x10 be=4'hF, then load @0x10 (WAIT_CYCLES=2) -> rsp_valid 3 cycles after each accept, rdata=0xDEADBEEF.
//  3 Byte merge: store 0x11223344 be=4'hF, store 0xAABBCCDD be=4'b0101 @0x20 -> load 0x11BB33DD.
//  4 Backpressure: hold rsp_ready=0 10 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout.
//  5 WAIT_CYCLES=0 build: back-to-back loads with rsp_ready=1 -> accept every 2nd cycle, latency 1.
//  6 DMEM_RANGE_CHECK_EN, ADDR_W=14: load @0x0001_0000 -> rsp_err=1, rdata=0; store there leaves mem[0] unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

   localparam int unsigned DMEM_DATA_W = 32;
   localparam int unsigned BYTE_LANES  = DMEM_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Replace each byte of old_word whose enable bit is set with the byte from new_word.
   function automatic logic [DMEM_DATA_W-1:0] merge_be(
      input logic [DMEM_DATA_W-1:0] old_word,
      input logic [DMEM_DATA_W-1:0] new_word,
      input logic [BYTE_LANES-1:0]  be
   );
      logic [DMEM_DATA_W-1:0] r;
      r = old_word;
      for (int unsigned i = 0; i < BYTE_LANES; i++) begin
         if (be[i]) r[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: asynchronous read, synchronous byte-enabled write.
// Contents are intentionally not reset.
module dmem_array #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   be,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Byte-lane write on the rising edge.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < DATA_W/8; i++) begin
            if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // Combinational read of the addressed word.
   always_comb begin
      rdata = mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, fixed-latency valid/ready response out.
// Optional range check enabled by defining DMEM_RANGE_CHECK_EN (adds rsp_err port).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 14,
   parameter int unsigned DATA_W      = DMEM_DATA_W,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [31:0]         req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                busy
`ifdef DMEM_RANGE_CHECK_EN
   ,
   output logic                rsp_err
`endif
);

   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 we_q;
   logic [ADDR_W-1:0]    idx_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [DATA_W/8-1:0]  be_q;
   logic                 oor_q;

   logic                 req_oor;
   logic                 a_we, a_oor, commit, mem_we;
   logic [ADDR_W-1:0]    a_idx;
   logic [DATA_W-1:0]    a_wdata, mem_rdata, merged;
   logic [DATA_W/8-1:0]  a_be;
   logic                 rsp_err_q;

`ifdef DMEM_RANGE_CHECK_EN
   logic unused_addr;
   assign unused_addr = ^req_addr[1:0];
   assign req_oor     = |req_addr[31:ADDR_W+2];
   assign rsp_err     = rsp_err_q;
`else
   logic unused_addr;
   assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0], rsp_err_q};
   assign req_oor     = 1'b0;
`endif

   // State and wait-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter update and handshake outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the request at acceptance; later input changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         oor_q   <= 1'b0;
      end else if (state_q == IDLE && req_valid) begin
         we_q    <= req_we;
         idx_q   <= req_addr[ADDR_W+1:2];
         wdata_q <= req_wdata;
         be_q    <= req_be;
         oor_q   <= req_oor;
      end
   end

   // With zero wait cycles the commit edge is the acceptance edge, so the live
   // request is used in IDLE and the latched copy otherwise.
   always_comb begin
      if (state_q == IDLE) begin
         a_we    = req_we;
         a_idx   = req_addr[ADDR_W+1:2];
         a_wdata = req_wdata;
         a_be    = req_be;
         a_oor   = req_oor;
      end else begin
         a_we    = we_q;
         a_idx   = idx_q;
         a_wdata = wdata_q;
         a_be    = be_q;
         a_oor   = oor_q;
      end
      commit = (state_d == RESP) && (state_q != RESP);
      mem_we = commit && rst_n && a_we && !a_oor;
      merged = merge_be(mem_rdata, a_wdata, a_be);
   end

   dmem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (a_idx),
      .wdata (a_wdata),
      .be    (a_be),
      .rdata (mem_rdata)
   );

   // Response data register, loaded on the edge that enters RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata <= '0;
         rsp_err_q <= 1'b0;
      end else if (commit) begin
         rsp_err_q <= a_oor;
         if (a_oor)     rsp_rdata <= '0;
         else if (a_we) rsp_rdata <= merged;
         else           rsp_rdata <= mem_rdata;
      end
   end

endmodule
